nibble_serial_addsub: RTL and testbench

- Sequential 16-bit two's-complement add/subtract unit built around one instantiated cla_4bit slice.
- Feeds the slice one operand nibble per cycle and consumes its Sum, P and G outputs to chain the carry.
- Provides an area-reduced ALU add/sub path with a start/done handshake, signed saturation and Z/N/V flags for the flag register.

---
 rtl/nibble_serial_addsub.sv | 232 +++++++++++++++++++++++
 tb/tb_nibble_serial_addsub.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// Purpose : 16-bit (4*NIBBLES) two's-complement add/sub, one nibble per cycle through a cla_4bit slice.
// Latency : done pulses in the cycle after the NIBBLES-th edge following start acceptance.
// Backpr. : none; start is only accepted in IDLE or DONE and is ignored while busy.
//
// Ports (nibble_serial_addsub):
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start, sub      request an operation; sub=1 selects A-B (both sampled on acceptance)
//   A, B            operands, captured on acceptance, free to change afterwards
//   busy, done      busy while nibbles are processed; done is a one-cycle result-valid pulse
//   Sum             result (saturated when SAT=1), held until the next completed operation
//   Ovfl, Z, N      signed overflow of the raw sum, zero and negative of the final Sum

// ---------------------------------------------------------------------------
// cla_4bit: single 4-bit carry-lookahead slice.
// Produces the nibble sum plus group propagate/generate so the caller can
// form the outgoing carry as g | (p & cin) without a ripple chain.
// ---------------------------------------------------------------------------
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);

    logic [3:0] bit_p;
    logic [3:0] bit_g;
    logic [3:0] c;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Lookahead carries into each bit position, all derived from cin directly.
    assign c[0] = cin;
    assign c[1] = bit_g[0] | (bit_p[0] & cin);
    assign c[2] = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
    assign c[3] = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
                | (bit_p[2] & bit_p[1] & bit_p[0] & cin);

    assign sum = bit_p ^ c;

    // Group terms deliberately exclude cin.
    assign p = &bit_p;
    assign g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
             | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);

endmodule

// ---------------------------------------------------------------------------
// nibble_serial_addsub: top level.
// ---------------------------------------------------------------------------
module nibble_serial_addsub #(
    parameter int NIBBLES = 4,
    parameter bit SAT     = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] Sum,
    output logic                 Ovfl,
    output logic                 Z,
    output logic                 N
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MAX_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured operands. b_eff already holds ~B for subtraction; the +1 of
    // the two's complement is supplied by seeding the carry with sub.
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_eff;
    logic          carry;
    logic [CW-1:0] cnt;
    logic [W-1:0]  raw;

    logic          accept;
    logic          last_nib;

    logic [3:0]    slice_a;
    logic [3:0]    slice_b;
    logic [3:0]    slice_sum;
    logic          slice_p;
    logic          slice_g;

    logic [W-1:0]  raw_upd;
    logic          ovfl_fin;
    logic [W-1:0]  sum_fin;

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_nib = (cnt == CW'(NIBBLES - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Back-to-back acceptance straight out of DONE.
                state_nxt = start ? RUN : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: one nibble through the shared slice per RUN cycle
    // ------------------------------------------------------------------
    assign slice_a = a_reg[{cnt, 2'b00} +: 4];
    assign slice_b = b_eff[{cnt, 2'b00} +: 4];

    cla_4bit u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry),
        .sum (slice_sum),
        .p   (slice_p),
        .g   (slice_g)
    );

    // Raw sum including the nibble being produced this cycle; on the last
    // nibble this is the complete result, so flags can be registered on the
    // same edge instead of one cycle later.
    always_comb begin
        raw_upd = raw;
        raw_upd[{cnt, 2'b00} +: 4] = slice_sum;
    end

    // Sign-based overflow: operands of equal sign producing a result of the
    // other sign. The carry out of the top nibble is not used.
    assign ovfl_fin = (a_reg[W-1] == b_eff[W-1]) && (raw_upd[W-1] != a_reg[W-1]);

    // On overflow the true result has the sign of A, so clamp toward it.
    always_comb begin
        sum_fin = raw_upd;
        if (SAT && ovfl_fin) begin
            sum_fin = a_reg[W-1] ? MAX_NEG : MAX_POS;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_eff <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            raw   <= '0;
        end else if (accept) begin
            a_reg <= A;
            b_eff <= sub ? ~B : B;
            carry <= sub;
            cnt   <= '0;
            raw   <= '0;
        end else if (state == RUN) begin
            raw   <= raw_upd;
            carry <= slice_g | (slice_p & carry);
            if (!last_nib) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Result and flags change only on the RUN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum  <= '0;
            Ovfl <= 1'b0;
            Z    <= 1'b0;
            N    <= 1'b0;
        end else if ((state == RUN) && last_nib) begin
            Sum  <= sum_fin;
            Ovfl <= ovfl_fin;
            Z    <= (sum_fin == '0);
            N    <= sum_fin[W-1];
        end
    end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Purpose : checks nibble_serial_addsub (SAT=1 and SAT=0 instances) against an integer-arithmetic model.
// Latency : expects done exactly 4 edges after acceptance, one op per 5 cycles back-to-back.
// Backpr. : exercises start held high during RUN and reset aborting a running op.
module tb_nibble_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;

    logic        s_busy, s_done, s_ovfl, s_z, s_n;
    logic [15:0] s_sum;
    logic        w_busy, w_done, w_ovfl, w_z, w_n;
    logic [15:0] w_sum;

    int checks;
    int fails;

    typedef struct packed {
        logic [15:0] sum;
        logic        v;
        logic        z;
        logic        n;
    } exp_t;

    nibble_serial_addsub #(.NIBBLES(4), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(s_busy), .done(s_done), .Sum(s_sum), .Ovfl(s_ovfl), .Z(s_z), .N(s_n)
    );

    nibble_serial_addsub #(.NIBBLES(4), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .A(A), .B(B),
        .busy(w_busy), .done(w_done), .Sum(w_sum), .Ovfl(w_ovfl), .Z(w_z), .N(w_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed arithmetic, then range check / clamp.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input logic sat);
        exp_t e;
        int   ia, ib, r;
        ia = int'($signed(a));
        ib = int'($signed(b));
        r  = s ? (ia - ib) : (ia + ib);
        e.v = (r > 32767) || (r < -32768);
        if (sat && e.v)
            e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
        else
            e.sum = r[15:0];
        e.z = (e.sum == 16'h0000);
        e.n = e.sum[15];
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
        exp_t es, ew;
        es = model(a, b, s, 1'b1);
        ew = model(a, b, s, 1'b0);
        check({tag, " sat.Sum"},  32'(s_sum),  32'(es.sum));
        check({tag, " sat.flags"}, {29'd0, s_ovfl, s_z, s_n}, {29'd0, es.v, es.z, es.n});
        check({tag, " wrap.Sum"}, 32'(w_sum),  32'(ew.sum));
        check({tag, " wrap.flags"}, {29'd0, w_ovfl, w_z, w_n}, {29'd0, ew.v, ew.z, ew.n});
    endtask

    // Call at a negedge with the DUTs in IDLE or DONE; returns at the negedge
    // of the DONE cycle so the next call is accepted back-to-back.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic s);
        int lat;
        bit got;
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
        check({tag, " busy"}, {30'd0, s_busy, w_busy}, 32'd3);
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (s_done) got = 1'b1;
            else if (s_busy !== 1'b1) check({tag, " busy_hold"}, 32'(s_busy), 32'd1);
        end
        check({tag, " done_seen"}, 32'(got), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'd4);
        check({tag, " done_state"}, {29'd0, w_done, s_busy, w_busy}, 32'd4);
        check_results(tag, a, b, s);
    endtask

    logic [15:0] pa [0:30];
    logic [15:0] pb [0:30];
    logic        ps [0:30];
    logic [15:0] held_s, held_w;
    exp_t        e1;

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        sub    = 1'b0;
        A      = 16'h0;
        B      = 16'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset.ctrl", {28'd0, s_busy, s_done, w_busy, w_done}, 32'd0);
        check("reset.sat", {13'd0, s_sum, s_ovfl, s_z, s_n}, 32'd0);
        check("reset.wrap", {13'd0, w_sum, w_ovfl, w_z, w_n}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("basic_add", 16'h1234, 16'h0FCF, 1'b0);
        check("basic_add.const", 32'(s_sum), 32'h2203);

        // Reset mid-RUN: abort during nibble 2, no done afterwards
        A = 16'h4321; B = 16'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.ctrl", {28'd0, s_busy, s_done, w_busy, w_done}, 32'd0);
        check("abort.sat", {13'd0, s_sum, s_ovfl, s_z, s_n}, 32'd0);
        check("abort.wrap", {13'd0, w_sum, w_ovfl, w_z, w_n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort.no_done", {28'd0, s_busy, s_done, w_busy, w_done}, 32'd0);
        end
        run_op("post_abort", 16'h0001, 16'h0001, 1'b0);
        check("post_abort.const", 32'(s_sum), 32'h0002);

        // Directed corners, issued back-to-back out of DONE
        run_op("ripple", 16'h0FFF, 16'h0001, 1'b0);
        check("ripple.const", 32'(s_sum), 32'h1000);
        run_op("zero", 16'h0005, 16'h0005, 1'b1);
        check("zero.const", {15'd0, s_sum, s_z}, {15'd0, 16'h0000, 1'b1});
        run_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0);
        check("pos_ovf.const", {13'd0, s_sum, s_ovfl, s_n, w_n}, {13'd0, 16'h7FFF, 1'b1, 1'b0, 1'b1});
        check("pos_ovf.wrapconst", 32'(w_sum), 32'h8000);
        run_op("neg_ovf", 16'h8000, 16'h0001, 1'b1);
        check("neg_ovf.const", {14'd0, s_sum, s_ovfl, s_n}, {14'd0, 16'h8000, 1'b1, 1'b1});
        run_op("sub_min", 16'h0000, 16'h8000, 1'b1);
        run_op("sub_min2", 16'hFFFF, 16'h8000, 1'b1);
        run_op("neg_add", 16'h8000, 16'h8000, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ((i % 4) == 1) ra = {ra[15], {15{~ra[15]}}};
            run_op($sformatf("rand%0d", i), ra, rb, 1'($urandom));
            if ((i % 3) == 0) @(negedge clk);
        end

        // start held high continuously, operands change every cycle
        @(negedge clk);
        held_s = s_sum;
        held_w = w_sum;
        start  = 1'b1;
        pa[0] = 16'($urandom); pb[0] = 16'($urandom); ps[0] = 1'($urandom);
        A = pa[0]; B = pb[0]; sub = ps[0];
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("stream.done", {30'd0, s_done, w_done}, ((e % 5) == 4) ? 32'd3 : 32'd0);
            check("stream.busy", 32'(s_busy), ((e % 5) != 4) ? 32'd1 : 32'd0);
            if ((e % 5) == 4) begin
                check_results("stream", pa[e-4], pb[e-4], ps[e-4]);
                e1 = model(pa[e-4], pb[e-4], ps[e-4], 1'b1);
                held_s = e1.sum;
                e1 = model(pa[e-4], pb[e-4], ps[e-4], 1'b0);
                held_w = e1.sum;
            end else begin
                check("stream.stable", {s_sum, w_sum}, {held_s, held_w});
            end
            pa[e+1] = 16'($urandom); pb[e+1] = 16'($urandom); ps[e+1] = 1'($urandom);
            A = pa[e+1]; B = pb[e+1]; sub = ps[e+1];
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
